ysyx_22041752_memsys: RTL and testbench

Memory subsystem sitting directly downstream of the CPU core's instruction-SRAM and data-SRAM ports.
- Provides a dual-port, one-cycle-latency synchronous RAM with byte write enables.
- Adds an MMIO decode for a free-running cycle timer and a buffered serial-TX FIFO.
- Raises sticky error flags on out-of-range accesses and FIFO overflow.

---
 rtl/ysyx_22041752_memsys_pkg.sv | 30 +++
 rtl/ysyx_22041752_memsys_if.sv | 49 ++++
 rtl/ysyx_22041752_txfifo.sv | 51 +++++
 rtl/ysyx_22041752_memsys.sv | 121 ++++++++++++
 tb/tb_ysyx_22041752_memsys.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041752_memsys_pkg.sv
// Shared definitions for the ysyx_22041752 memory subsystem: MMIO addresses,
// the default RAM base and the address-decode encoding with its helper.
package ysyx_22041752_memsys_pkg;

  localparam logic [63:0] MMIO_TIMER   = 64'hA000_0048;
  localparam logic [63:0] MMIO_SERIAL  = 64'hA000_03F8;
  localparam logic [63:0] RAM_BASE_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    DEC_RAM    = 2'd0,
    DEC_TIMER  = 2'd1,
    DEC_SERIAL = 2'd2,
    DEC_NONE   = 2'd3
  } dec_e;

  // Classify a byte address. mmio_ok is low for the instruction port, which
  // only ever fetches from RAM; MMIO addresses then decode as DEC_NONE.
  function automatic dec_e decode(input logic [63:0] addr,
                                  input logic [63:0] base,
                                  input logic [63:0] span,
                                  input logic        mmio_ok);
    dec_e d;
    d = DEC_NONE;
    if ((addr >= base) && ((addr - base) < span)) d = DEC_RAM;
    else if (mmio_ok && (addr == MMIO_TIMER))     d = DEC_TIMER;
    else if (mmio_ok && (addr == MMIO_SERIAL))    d = DEC_SERIAL;
    return d;
  endfunction

endpackage

// File: rtl/ysyx_22041752_memsys_if.sv
// Core-facing bus of the memory subsystem: instruction port, data port,
// serial TX stream and sticky error flags.
//
// Handshake: uart_tx_valid/uart_tx_ready follow strict valid/ready rules. A
// byte transfers on a rising edge where both are high; once valid is raised
// it stays high and uart_tx_data stays stable until that transfer happens.
// The SRAM ports are request-only: en qualifies a request, rdata appears one
// cycle later and holds otherwise.
interface ysyx_22041752_memsys_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int WEN_W  = 8
);
  logic              inst_sram_en;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_rdata;
  logic              data_sram_en;
  logic [WEN_W-1:0]  data_sram_wen;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [DATA_W-1:0] data_sram_wdata;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              uart_tx_valid;
  logic [7:0]        uart_tx_data;
  logic              uart_tx_ready;
  logic              mem_err;
  logic              uart_ovf;

  // Core side: issues requests, consumes read data and the serial stream.
  modport master (
    output inst_sram_en, inst_sram_addr,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata,
    input  uart_tx_valid, uart_tx_data,
    output uart_tx_ready,
    input  mem_err, uart_ovf
  );

  // Memory subsystem side.
  modport slave (
    input  inst_sram_en, inst_sram_addr,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata,
    output uart_tx_valid, uart_tx_data,
    input  uart_tx_ready,
    output mem_err, uart_ovf
  );
endinterface

// File: rtl/ysyx_22041752_txfifo.sv
// Synchronous serial-TX FIFO. No bypass: a pushed byte becomes visible at the
// head one cycle later. Pointers carry one extra bit so full and empty are
// distinguishable. A push into a full FIFO is accepted only if a pop happens
// in the same cycle; otherwise it is dropped and the sticky ovf flag is set.
module ysyx_22041752_txfifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         pop_ok;
  logic         push_ok;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Pointer and overflow-flag update; reset discards any pending bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok)          wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)           rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) ovf    <= 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ysyx_22041752_memsys.sv
// Memory subsystem top: dual-port one-cycle-latency RAM with byte enables,
// MMIO cycle timer and serial TX FIFO, sticky out-of-range / overflow flags.
// Optional feature macro: YSYX_22041752_MMIO_SKIP_EN adds the registered
// mmio_skip output, high alongside data_sram_rdata for MMIO data accesses.
module ysyx_22041752_memsys
  import ysyx_22041752_memsys_pkg::*;
#(
  parameter int          ADDR_W     = 64,
  parameter int          DATA_W     = 64,
  parameter int          WEN_W      = 8,
  parameter int          DEPTH      = 4096,
  parameter logic [63:0] RAM_BASE   = RAM_BASE_DEF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ysyx_22041752_memsys_if.slave bus
`ifdef YSYX_22041752_MMIO_SKIP_EN
  ,
  output logic                  mmio_skip
`endif
);
  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [63:0] RAM_SPAN = 64'(DEPTH) * 64'd8;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [63:0]       timer;

  dec_e              i_dec;
  dec_e              d_dec;
  logic [IDX_W-1:0]  i_idx;
  logic [IDX_W-1:0]  d_idx;
  logic              d_rd;
  logic              d_wr;
  logic              err_set;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              unused_fifo_full;

  // Address decode and word indices; the low three address bits are ignored.
  always_comb begin
    i_dec   = decode(64'(bus.inst_sram_addr), RAM_BASE, RAM_SPAN, 1'b0);
    d_dec   = decode(64'(bus.data_sram_addr), RAM_BASE, RAM_SPAN, 1'b1);
    i_idx   = IDX_W'((64'(bus.inst_sram_addr) - RAM_BASE) >> 3);
    d_idx   = IDX_W'((64'(bus.data_sram_addr) - RAM_BASE) >> 3);
    d_rd    = bus.data_sram_en && (bus.data_sram_wen == '0);
    d_wr    = bus.data_sram_en && (bus.data_sram_wen != '0);
    err_set = (bus.inst_sram_en && (i_dec == DEC_NONE)) ||
              (bus.data_sram_en && (d_dec == DEC_NONE));
  end

  // Free-running cycle timer, wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (reset) timer <= '0;
    else       timer <= timer + 64'd1;
  end

  // RAM byte-lane writes; contents are not reset, and nothing lands while
  // reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset && d_wr && (d_dec == DEC_RAM)) begin
      for (int i = 0; i < WEN_W; i++) begin
        if (bus.data_sram_wen[i]) ram[d_idx][i*8 +: 8] <= bus.data_sram_wdata[i*8 +: 8];
      end
    end
  end

  // Registered read ports and sticky out-of-range flag. Reads sample the
  // array before this edge's write, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.inst_sram_rdata <= '0;
      bus.data_sram_rdata <= '0;
      bus.mem_err         <= 1'b0;
    end else begin
      if (bus.inst_sram_en) begin
        bus.inst_sram_rdata <= (i_dec == DEC_RAM) ? ram[i_idx] : '0;
      end
      if (d_rd) begin
        case (d_dec)
          DEC_RAM:   bus.data_sram_rdata <= ram[d_idx];
          DEC_TIMER: bus.data_sram_rdata <= DATA_W'(timer);
          default:   bus.data_sram_rdata <= '0;
        endcase
      end
      if (err_set) bus.mem_err <= 1'b1;
    end
  end

  assign fifo_push         = d_wr && (d_dec == DEC_SERIAL) && bus.data_sram_wen[0];
  assign fifo_pop          = bus.uart_tx_valid && bus.uart_tx_ready;
  assign bus.uart_tx_valid = !fifo_empty;
  assign unused_fifo_full  = fifo_full;

  ysyx_22041752_txfifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_txfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.data_sram_wdata[7:0]),
    .pop       (fifo_pop),
    .head_data (bus.uart_tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ovf       (bus.uart_ovf)
  );

`ifdef YSYX_22041752_MMIO_SKIP_EN
  // One-cycle pulse aligned with data_sram_rdata for MMIO data accesses.
  always_ff @(posedge clk) begin
    if (reset) mmio_skip <= 1'b0;
    else       mmio_skip <= bus.data_sram_en && ((d_dec == DEC_TIMER) || (d_dec == DEC_SERIAL));
  end
`endif

endmodule

// File: tb/tb_ysyx_22041752_memsys.sv
// Directed bench for ysyx_22041752_memsys: RAM ports, collisions, timer,
// serial FIFO with overflow, out-of-range errors and mid-operation reset.
module tb_ysyx_22041752_memsys;
  localparam logic [63:0] T_TIMER  = 64'hA000_0048;
  localparam logic [63:0] T_SERIAL = 64'hA000_03F8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  logic [63:0] t1;
  logic [63:0] t2;

  ysyx_22041752_memsys_if #(.ADDR_W(64), .DATA_W(64), .WEN_W(8)) bus ();

  ysyx_22041752_memsys dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic data_wr(input logic [63:0] addr, input logic [7:0] wen, input logic [63:0] wdata);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    tick();
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 8'h00;
  endtask

  task automatic data_rd(input logic [63:0] addr);
    bus.data_sram_en   = 1'b1;
    bus.data_sram_wen  = 8'h00;
    bus.data_sram_addr = addr;
    tick();
    bus.data_sram_en   = 1'b0;
  endtask

  task automatic inst_rd(input logic [63:0] addr);
    bus.inst_sram_en   = 1'b1;
    bus.inst_sram_addr = addr;
    tick();
    bus.inst_sram_en   = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.inst_sram_en    = 1'b0;
    bus.inst_sram_addr  = '0;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = '0;
    bus.data_sram_addr  = '0;
    bus.data_sram_wdata = '0;
    bus.uart_tx_ready   = 1'b0;
    tick();
    tick();
    check("rst_inst_rdata", bus.inst_sram_rdata, 64'h0);
    check("rst_data_rdata", bus.data_sram_rdata, 64'h0);
    check("rst_tx_valid", 64'(bus.uart_tx_valid), 64'h0);
    check("rst_mem_err", 64'(bus.mem_err), 64'h0);
    check("rst_uart_ovf", 64'(bus.uart_ovf), 64'h0);
    reset = 1'b0;

    // Timer: cycle k after the last reset edge holds value k.
    repeat (10) tick();
    data_rd(T_TIMER);
    t1 = bus.data_sram_rdata;
    check("timer_first", t1, 64'd10);
    repeat (4) tick();
    data_rd(T_TIMER);
    t2 = bus.data_sram_rdata;
    check("timer_second", t2, 64'd15);
    check("timer_delta", t2 - t1, 64'd5);
    data_wr(T_TIMER, 8'hFF, 64'h1234);
    data_rd(T_SERIAL);
    check("serial_read_zero", bus.data_sram_rdata, 64'h0);
    check("mmio_no_err", 64'(bus.mem_err), 64'h0);

    // Preload and instruction fetch.
    data_wr(64'h8000_0000, 8'hFF, 64'h0000_0013_0000_0297);
    inst_rd(64'h8000_0000);
    check("inst_fetch", bus.inst_sram_rdata, 64'h0000_0013_0000_0297);
    check("inst_no_err", 64'(bus.mem_err), 64'h0);

    // Byte-enable write over all-ones.
    data_wr(64'h8000_0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    data_wr(64'h8000_0008, 8'h0F, 64'h1122_3344_5566_7788);
    data_rd(64'h8000_0008);
    check("byte_write", bus.data_sram_rdata, 64'hFFFF_FFFF_5566_7788);

    // Same-word collision: instruction read sees the old data.
    data_wr(64'h8000_0010, 8'hFF, 64'h0123_4567_89AB_CDEF);
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = 8'hFF;
    bus.data_sram_addr  = 64'h8000_0010;
    bus.data_sram_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    bus.inst_sram_en    = 1'b1;
    bus.inst_sram_addr  = 64'h8000_0010;
    tick();
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 8'h00;
    bus.inst_sram_en    = 1'b0;
    check("collide_old", bus.inst_sram_rdata, 64'h0123_4567_89AB_CDEF);
    check("write_holds_rdata", bus.data_sram_rdata, 64'hFFFF_FFFF_5566_7788);
    inst_rd(64'h8000_0013);
    check("collide_new", bus.inst_sram_rdata, 64'hAAAA_AAAA_AAAA_AAAA);

    // Last RAM word.
    data_wr(64'h8000_7FF8, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
    data_rd(64'h8000_7FFF);
    check("last_word", bus.data_sram_rdata, 64'h5A5A_5A5A_5A5A_5A5A);
    check("last_word_no_err", 64'(bus.mem_err), 64'h0);

    // Serial FIFO: lane 0 disabled does not push.
    data_wr(T_SERIAL, 8'hFE, 64'h0000_0000_0000_0033);
    check("no_lane0_push", 64'(bus.uart_tx_valid), 64'h0);

    // Fill to eight, then overflow with a ninth byte.
    for (int i = 0; i < 9; i++) begin
      data_wr(T_SERIAL, 8'h01, {56'hABCDEF_0011_2233, 8'(8'h41 + i)});
      if (i == 0) begin
        check("push_valid", 64'(bus.uart_tx_valid), 64'h1);
        check("push_head", 64'(bus.uart_tx_data), 64'h41);
      end
      if (i == 7) check("full_no_ovf", 64'(bus.uart_ovf), 64'h0);
    end
    check("ovf_set", 64'(bus.uart_ovf), 64'h1);
    check("head_stable", 64'(bus.uart_tx_data), 64'h41);
    bus.uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 64'(bus.uart_tx_valid), 64'h1);
      check("drain_data", 64'(bus.uart_tx_data), 64'(8'h41 + i));
      tick();
    end
    check("drained_empty", 64'(bus.uart_tx_valid), 64'h0);

    // Full FIFO with simultaneous pop accepts the push.
    bus.uart_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) data_wr(T_SERIAL, 8'h01, 64'(8'h50 + i));
    bus.uart_tx_ready = 1'b1;
    data_wr(T_SERIAL, 8'h01, 64'h58);
    for (int i = 0; i < 8; i++) begin
      check("fullpop_data", 64'(bus.uart_tx_data), 64'(8'h51 + i));
      tick();
    end
    check("fullpop_empty", 64'(bus.uart_tx_valid), 64'h0);
    bus.uart_tx_ready = 1'b0;

    // Out-of-range data read.
    data_rd(64'h7FFF_FFF8);
    check("oor_rdata", bus.data_sram_rdata, 64'h0);
    check("oor_err", 64'(bus.mem_err), 64'h1);

    // Reset mid-operation: pending byte and same-cycle RAM write discarded.
    data_wr(T_SERIAL, 8'h01, 64'h77);
    check("pre_rst_valid", 64'(bus.uart_tx_valid), 64'h1);
    reset               = 1'b1;
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = 8'hFF;
    bus.data_sram_addr  = 64'h8000_0000;
    bus.data_sram_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 8'h00;
    check("rst2_inst_rdata", bus.inst_sram_rdata, 64'h0);
    check("rst2_data_rdata", bus.data_sram_rdata, 64'h0);
    check("rst2_mem_err", 64'(bus.mem_err), 64'h0);
    check("rst2_uart_ovf", 64'(bus.uart_ovf), 64'h0);
    check("rst2_tx_valid", 64'(bus.uart_tx_valid), 64'h0);
    reset = 1'b0;
    inst_rd(64'h8000_0000);
    check("rst2_no_write", bus.inst_sram_rdata, 64'h0000_0013_0000_0297);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
